// File: rtl/interact_pkg.sv
// Shared constants and helpers for the APF interact register bank: default bridge
// addresses, well-known register slots and the register address decode helper.
package interact_pkg;

    localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0000;
    localparam logic [31:0] DEF_REG_BASE  = 32'hF100_0000;

    // Conventional slot assignments used by cores that share this bank layout
    localparam int FILTERS_IDX    = 0;
    localparam int NVRAM_IDX      = 1;
    localparam int ANALOGIZER_IDX = 2;

    typedef logic [4:0] regbank_idx_t;

    // A read to an unmapped address keeps the last returned word on the bus
    localparam bit RD_MISS_HOLD = 1'b1;

    function automatic logic [31:0] regbank_addr(input logic [31:0] base,
                                                 input int stride_log2,
                                                 input regbank_idx_t idx);
        return base + ({27'h0, idx} << stride_log2);
    endfunction

endpackage

// File: rtl/interact_regbank_if.sv
// APF bridge bus as seen by the register bank: single-cycle read/write strobes
// with a registered read data return.
interface interact_regbank_if;
    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;

    modport master (
        output bridge_addr,
        output bridge_wr,
        output bridge_wr_data,
        output bridge_rd,
        input  bridge_rd_data
    );

    modport slave (
        input  bridge_addr,
        input  bridge_wr,
        input  bridge_wr_data,
        input  bridge_rd,
        output bridge_rd_data
    );
endinterface

// File: rtl/interact_rst_stretch.sv
// Core-reset pulse stretcher: holds core_reset for RST_CYCLES cycles after the
// last trigger or after system reset falls.
module interact_rst_stretch #(
    parameter int RST_CYCLES = 10000
) (
    input  logic clk_74a,
    input  logic reset,
    input  logic trig,
    output logic core_reset,
    output logic busy
);

    localparam int CW = $clog2(RST_CYCLES + 1);

    logic [CW-1:0] count;

    // Reset and retriggers both reload, so a pulse is only ever extended
    always_ff @(posedge clk_74a) begin
        if (reset || trig) begin
            count <= CW'(RST_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy       = (count != '0);
    assign core_reset = busy | reset;

endmodule

// File: rtl/interact_regbank.sv
// APF bridge register bank: NUM_REGS 32-bit registers at a power-of-two stride,
// per-register write/reset masks, update strobes and a core-reset control word.
module interact_regbank
    import interact_pkg::*;
#(
    parameter int                     NUM_REGS    = 8,
    parameter logic [31:0]            REG_BASE    = DEF_REG_BASE,
    parameter int                     STRIDE_LOG2 = 24,
    parameter logic [31:0]            CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter int                     RST_CYCLES  = 10000,
    parameter logic [NUM_REGS-1:0]    WR_MASK     = '1,
    parameter logic [NUM_REGS-1:0]    RST_MASK    = '0,
    parameter logic [NUM_REGS*32-1:0] INIT        = '0
) (
    input  logic                     clk_74a,
    input  logic                     reset,
    interact_regbank_if.slave        bus,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      reg_upd,
    output logic                     core_reset,
    output logic                     core_reset_busy
);

    logic [31:0]         reg_q [NUM_REGS];
    logic [NUM_REGS-1:0] hit;
    logic [NUM_REGS-1:0] wr_acc;
    logic                rd_hit;
    logic [31:0]         rd_val;
    logic                ctrl_hit;
    logic                trig;

    // Exact-match decode; addresses past NUM_REGS never alias back onto the bank
    always_comb begin
        hit    = '0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.bridge_addr == regbank_addr(REG_BASE, STRIDE_LOG2, regbank_idx_t'(i))) begin
                hit[i] = 1'b1;
                rd_hit = 1'b1;
                rd_val = reg_q[i];
            end
        end
        ctrl_hit = (bus.bridge_addr == CTRL_ADDR);
        wr_acc   = (bus.bridge_wr && !reset) ? (hit & WR_MASK) : '0;
        trig     = !reset && bus.bridge_wr && (ctrl_hit || |(wr_acc & RST_MASK));
    end

    always_ff @(posedge clk_74a) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                reg_q[i] <= INIT[32*i +: 32];
            end else if (wr_acc[i]) begin
                reg_q[i] <= bus.bridge_wr_data;
            end
        end
        reg_upd <= reset ? '0 : wr_acc;
    end

    // Read mux samples pre-write contents, so a same-cycle write shows up one cycle later
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            bus.bridge_rd_data <= '0;
        end else if (bus.bridge_rd) begin
            if (rd_hit) begin
                bus.bridge_rd_data <= rd_val;
            end else if (ctrl_hit) begin
                bus.bridge_rd_data <= {30'h0, core_reset_busy, core_reset};
            end else if (!RD_MISS_HOLD) begin
                bus.bridge_rd_data <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[32*g +: 32] = reg_q[g];
    end

    interact_rst_stretch #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_stretch (
        .clk_74a    (clk_74a),
        .reset      (reset),
        .trig       (trig),
        .core_reset (core_reset),
        .busy       (core_reset_busy)
    );

endmodule

// File: tb/tb_interact_regbank.sv
// Directed bench for interact_regbank: reset stretch, decode, masks, strobes,
// read latency and core-reset retrigger behaviour.
module tb_interact_regbank;
    import interact_pkg::*;

    localparam int NR = 6;
    localparam int RC = 16;
    localparam logic [NR-1:0]    WRM  = 6'b11_1101;
    localparam logic [NR-1:0]    RSTM = 6'b00_0001;
    localparam logic [NR*32-1:0] INIT_V = {32'hA000_0005, 32'hA000_0004, 32'hA000_0003,
                                           32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    logic              clk_74a;
    logic              reset;
    logic [NR*32-1:0]  regs;
    logic [NR-1:0]     reg_upd;
    logic              core_reset;
    logic              core_reset_busy;

    interact_regbank_if bus ();

    interact_regbank #(
        .NUM_REGS    (NR),
        .REG_BASE    (32'hF100_0000),
        .STRIDE_LOG2 (24),
        .CTRL_ADDR   (32'hF000_0000),
        .RST_CYCLES  (RC),
        .WR_MASK     (WRM),
        .RST_MASK    (RSTM),
        .INIT        (INIT_V)
    ) dut (
        .clk_74a         (clk_74a),
        .reset           (reset),
        .bus             (bus),
        .regs            (regs),
        .reg_upd         (reg_upd),
        .core_reset      (core_reset),
        .core_reset_busy (core_reset_busy)
    );

    initial clk_74a = 1'b0;
    always #5 clk_74a = ~clk_74a;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [NR-1:0] exp_upd;
        int          reg_idx;
        logic [31:0] exp_reg;
        string       name;
    } vec_t;

    vec_t vecs [12];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk_74a);
        #1;
    endtask

    task automatic idle_bus;
        bus.bridge_wr      = 1'b0;
        bus.bridge_rd      = 1'b0;
        bus.bridge_addr    = 32'h0;
        bus.bridge_wr_data = 32'h0;
    endtask

    task automatic measure_pulse(output int n);
        #1;
        n = 0;
        while (core_reset === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'hF300_0000, 32'hDEAD_BEEF, 1'b0, 32'h0,          6'b00_0100, ANALOGIZER_IDX, 32'hDEAD_BEEF, "wr_reg2"};
        vecs[1]  = '{1'b0, 1'b1, 32'hF300_0000, 32'h0,         1'b1, 32'hDEAD_BEEF,  6'b00_0000, ANALOGIZER_IDX, 32'hDEAD_BEEF, "rd_reg2"};
        vecs[2]  = '{1'b1, 1'b0, 32'hF200_0000, 32'h0000_1234, 1'b0, 32'h0,          6'b00_0000, NVRAM_IDX,      32'hA000_0001, "wr_ro_reg1"};
        vecs[3]  = '{1'b0, 1'b1, 32'hF200_0000, 32'h0,         1'b1, 32'hA000_0001,  6'b00_0000, NVRAM_IDX,      32'hA000_0001, "rd_ro_reg1"};
        vecs[4]  = '{1'b1, 1'b0, 32'hF400_0000, 32'h0000_0005, 1'b0, 32'h0,          6'b00_1000, 3,              32'h0000_0005, "wr_reg3"};
        vecs[5]  = '{1'b1, 1'b0, 32'hF400_0000, 32'h0000_0005, 1'b0, 32'h0,          6'b00_1000, 3,              32'h0000_0005, "wr_reg3_same"};
        vecs[6]  = '{1'b1, 1'b1, 32'hF400_0000, 32'h0000_0009, 1'b1, 32'h0000_0005,  6'b00_1000, 3,              32'h0000_0009, "rdwr_reg3"};
        vecs[7]  = '{1'b0, 1'b1, 32'hF700_0000, 32'h0,         1'b1, 32'h0000_0005,  6'b00_0000, 3,              32'h0000_0009, "rd_miss_beyond"};
        vecs[8]  = '{1'b1, 1'b0, 32'hF700_0000, 32'h0000_0055, 1'b0, 32'h0,          6'b00_0000, FILTERS_IDX,    32'hA000_0000, "wr_miss_beyond"};
        vecs[9]  = '{1'b1, 1'b0, 32'hF100_0001, 32'h0000_0066, 1'b0, 32'h0,          6'b00_0000, FILTERS_IDX,    32'hA000_0000, "wr_off_addr"};
        vecs[10] = '{1'b0, 1'b1, 32'hF600_0000, 32'h0,         1'b1, 32'hA000_0005,  6'b00_0000, 5,              32'hA000_0005, "rd_reg5"};
        vecs[11] = '{1'b0, 1'b1, 32'hF000_0000, 32'h0,         1'b1, 32'h0000_0000,  6'b00_0000, 5,              32'hA000_0005, "rd_ctrl_idle"};

        // Power-on reset and release stretch
        idle_bus();
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_core_reset", {191'h0, core_reset}, {191'h0, 1'b1});
        chk("rst_reg_upd", {186'h0, reg_upd}, '0);
        chk("rst_rd_data", {160'h0, bus.bridge_rd_data}, '0);
        chk("rst_regs_init", regs, INIT_V);
        reset = 1'b0;
        measure_pulse(n);
        chk("release_pulse_len", 192'(n), 192'(RC));
        chk("regs_after_release", regs, INIT_V);

        // Table-driven single-cycle transactions
        for (int i = 0; i < 12; i++) begin
            bus.bridge_wr      = vecs[i].wr;
            bus.bridge_rd      = vecs[i].rd;
            bus.bridge_addr    = vecs[i].addr;
            bus.bridge_wr_data = vecs[i].wdata;
            tick();
            idle_bus();
            if (vecs[i].chk_rd) begin
                chk({vecs[i].name, "_rd"}, {160'h0, bus.bridge_rd_data}, {160'h0, vecs[i].exp_rd});
            end
            chk({vecs[i].name, "_upd"}, {186'h0, reg_upd}, {186'h0, vecs[i].exp_upd});
            chk({vecs[i].name, "_reg"}, {160'h0, regs[32*vecs[i].reg_idx +: 32]}, {160'h0, vecs[i].exp_reg});
            chk({vecs[i].name, "_no_core_reset"}, {191'h0, core_reset}, '0);
        end

        // Strobe lasts one cycle only
        tick();
        chk("upd_one_cycle", {186'h0, reg_upd}, '0);

        // Reset-mask register write, status read mid-pulse, retrigger at pulse cycle 10
        bus.bridge_wr      = 1'b1;
        bus.bridge_addr    = 32'hF100_0000;
        bus.bridge_wr_data = 32'h0000_CAFE;
        tick();
        idle_bus();
        chk("rstmask_upd", {186'h0, reg_upd}, {186'h0, 6'b00_0001});
        chk("rstmask_reg0", {160'h0, regs[32*FILTERS_IDX +: 32]}, {160'h0, 32'h0000_CAFE});
        chk("rstmask_busy", {191'h0, core_reset_busy}, {191'h0, 1'b1});
        n = 0;
        while (core_reset === 1'b1 && n < 200) begin
            n++;
            if (n == 5) begin
                bus.bridge_rd   = 1'b1;
                bus.bridge_addr = 32'hF000_0000;
            end
            if (n == 10) begin
                bus.bridge_wr      = 1'b1;
                bus.bridge_addr    = 32'hF000_0000;
                bus.bridge_wr_data = 32'h1234_5678;
            end
            tick();
            idle_bus();
            if (n == 5) begin
                chk("rd_ctrl_mid_pulse", {160'h0, bus.bridge_rd_data}, {160'h0, 32'h0000_0003});
            end
        end
        chk("retrigger_pulse_len", 192'(n), 192'(10 + RC));

        // System reset in the middle of a pulse gives a fresh full stretch
        bus.bridge_wr   = 1'b1;
        bus.bridge_addr = 32'hF000_0000;
        tick();
        idle_bus();
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("midpulse_reset_regs", regs, INIT_V);
        chk("midpulse_reset_rd_data", {160'h0, bus.bridge_rd_data}, '0);
        reset = 1'b0;
        measure_pulse(n);
        chk("midpulse_reset_len", 192'(n), 192'(RC));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
